// File: rtl/memory_access_unit.sv
// Memory-access pipeline stage: ALU results pass straight through, while a load
// or store holds the pipe with stall until the data memory acknowledges or times out.

package architecture_pkg;
   localparam int DATA_SIZE  = 32;
   localparam int GPR_SIZE   = 5;
   localparam int OP_WB_SIZE = 2;

   localparam logic [OP_WB_SIZE-1:0] WB_NONE     = 2'd0;
   localparam logic [OP_WB_SIZE-1:0] WB_REGISTER = 2'd1;
   localparam logic [OP_WB_SIZE-1:0] WB_MEMORY   = 2'd2;

   localparam logic [1:0] MEM_OP_NONE  = 2'b00;
   localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
   localparam logic [1:0] MEM_OP_STORE = 2'b10;
endpackage

module memory_access_unit
   import architecture_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic [1:0]            mem_op,
   input  logic [DATA_SIZE-1:0]  result_in,
   input  logic [DATA_SIZE-1:0]  store_data,
   input  logic [GPR_SIZE-1:0]   destination_in,
   input  logic [OP_WB_SIZE-1:0] writeback_in,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_SIZE-1:0]  mem_addr,
   output logic [DATA_SIZE-1:0]  mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_SIZE-1:0]  mem_rdata,
   output logic [DATA_SIZE-1:0]  result,
   output logic [DATA_SIZE-1:0]  data_in,
   output logic [GPR_SIZE-1:0]   destination,
   output logic [OP_WB_SIZE-1:0] writeback,
   output logic                  mem_error
);

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   state_t                  state;
   logic [7:0]              timeout_count;
   logic [DATA_SIZE-1:0]    held_addr;
   logic [GPR_SIZE-1:0]     held_destination;
   logic [OP_WB_SIZE-1:0]   held_writeback;
   logic                    held_is_store;

   logic is_load;
   logic is_store;

   // Reserved encoding 11 decodes as neither, so it flows through as an ALU op.
   assign is_load  = (mem_op == MEM_OP_LOAD);
   assign is_store = (mem_op == MEM_OP_STORE);

   // Combinational so upstream sees the release in the same cycle state returns to IDLE.
   assign stall = (state == ACCESS);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         timeout_count    <= '0;
         held_addr        <= '0;
         held_destination <= '0;
         held_writeback   <= WB_NONE;
         held_is_store    <= 1'b0;
         mem_req          <= 1'b0;
         mem_we           <= 1'b0;
         mem_addr         <= '0;
         mem_wdata        <= '0;
         mem_error        <= 1'b0;
         result           <= '0;
         data_in          <= '0;
         destination      <= '0;
         writeback        <= WB_NONE;
      end else begin
         // NOTE: non-blocking assignments, so these bubble defaults are simply
         // overridden by any later assignment below and all reads see pre-edge values.
         mem_error   <= 1'b0;
         result      <= '0;
         data_in     <= '0;
         destination <= '0;
         writeback   <= WB_NONE;

         case (state)
            IDLE: begin
               if (valid_in && (is_load || is_store)) begin
                  held_addr        <= result_in;
                  held_destination <= destination_in;
                  held_writeback   <= writeback_in;
                  held_is_store    <= is_store;
                  mem_req          <= 1'b1;
                  mem_we           <= is_store;
                  mem_addr         <= result_in;
                  mem_wdata        <= is_store ? store_data : '0;
                  timeout_count    <= '0;
                  state            <= ACCESS;
               end else if (valid_in) begin
                  result      <= result_in;
                  destination <= destination_in;
                  writeback   <= writeback_in;
               end
            end

            ACCESS: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  state     <= IDLE;
                  if (!held_is_store) begin
                     result      <= held_addr;
                     data_in     <= mem_rdata;
                     destination <= held_destination;
                     writeback   <= held_writeback;
                  end
               end else if (timeout_count == TIMEOUT_LIMIT) begin
                  // Abort: drop the request and flag it; the instruction is lost.
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  mem_error <= 1'b1;
                  state     <= IDLE;
               end else begin
                  timeout_count <= timeout_count + 8'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
